lsu_mem_sched: RTL and testbench
================================

Name: lsu_mem_sched

Overview:
- Load/store scheduler in front of the single data-memory port of the osyrys64 core.
- Arbitrates between the pipeline load requester and the store-buffer drain requester.
- Generates the doubleword-aligned address, byte-enable mask and shifted write data.
- Sequences each load through memory and then hands the raw doubleword to the reader (load formatter) using its valid_in/ready_out handshake.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a waiting store may lose arbitration before it gets priority
CNT_W, 3, width of the starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ld_valid  in  1  load request valid
ld_ready  out  1  load request accepted this cycle
ld_addr  in  64  load byte address
ld_f3  in  3  load funct3 (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
st_valid  in  1  store request valid
st_ready  out  1  store request accepted this cycle
st_addr  in  64  store byte address
st_data  in  64  store data, right-aligned
st_f3  in  3  store funct3 (000 SB, 001 SH, 010 SW, 011 SD)
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = write
mem_addr  out  64  {addr[63:3],3'b000}
mem_wdata  out  64  st_data << (8*addr[2:0])
mem_wstrb  out  8  write byte strobes
mem_gnt  in  1  memory accepts request
mem_rvalid  in  1  read data valid
mem_rdata  in  64  read doubleword
rd_valid_in  out  1  to reader valid_in
rd_mem_data  out  64  to reader mem_data (raw captured doubleword)
rd_be_mask  out  8  to reader be_mask
rd_f3  out  3  to reader f3
rd_is_load_64  out  1  to reader is_load_64 (1 iff f3==011)
rd_ready_out  in  1  from reader ready_out
misalign_err  out  1  one-cycle pulse: accepted request misaligned or illegal f3
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, starve_cnt=0, and all outputs 0. mem_req deasserts immediately, including mid-transaction. Any in-flight load is dropped.
- FSM states: IDLE, REQ, WAIT_RSP, DELIVER.
- IDLE arbitration:
  - Load wins over store unless starve_cnt==STARVE_LIMIT, in which case store wins.
  - ld_ready/st_ready are combinational and high only in IDLE for the winner. Acceptance is valid&&ready.
- starve_cnt:
  - +1 (saturating) each IDLE cycle with st_valid=1 where the load is granted.
  - Cleared when a store is accepted.
- Mask from addr[2:0] (o = offset):
  - byte: 8'h01<<o.
  - half: 8'h03<<o; misaligned if o[0].
  - word: 8'h0F<<o; misaligned if o[1:0]!=0.
  - double: 8'hFF; misaligned if o!=0.
- Misaligned or illegal f3 (load 111, store 1xx):
  - Request is still accepted (ready=1).
  - misalign_err pulses the next cycle.
  - No memory access; state stays IDLE.
- Accepted legal request: latch addr/mask/data/f3, then go to REQ next cycle.
- REQ: mem_req=1 with stable mem_we/addr/wdata/wstrb until mem_gnt. wstrb=mask for stores and 0 for loads.
  - Store + gnt: go to IDLE (posted write, no response).
  - Load + gnt: go to WAIT_RSP.
- WAIT_RSP: on mem_rvalid, capture mem_rdata and go to DELIVER. mem_rvalid in any other state is ignored.
- DELIVER: rd_valid_in=1 with rd_mem_data/rd_be_mask/rd_f3/rd_is_load_64 stable until rd_ready_out=1, then go to IDLE.
- Minimum load latency (gnt and rvalid immediate, reader ready): accept at edge 0, mem_req in cycle 1, rvalid in cycle 2, rd_valid_in in cycle 3.
- Minimum store occupancy: 2 cycles (accept, REQ).
- Only one outstanding transaction; no new accept while busy.

Test Plan:
- LB addr 0x1003, mem_rdata 0x00000000FF000000 -> mem_addr 0x1000; rd_be_mask 8'h08, rd_f3 000, rd_is_load_64 0, rd_mem_data equals rdata; rd_valid_in 3 cycles after accept.
- LD addr 0x2000 with mem_gnt delayed 2 cycles, rdata 0x123456789ABCDEF0 -> mem_req held 3 cycles, rd_be_mask 8'hFF, rd_is_load_64 1; with rd_ready_out low 2 cycles, rd_valid_in holds stable 3 cycles.
- SH addr 0x3006, data 0xBEEF -> mem_we 1, wstrb 8'hC0, wdata 0xBEEF000000000000, return to IDLE after gnt; reader sees no rd_valid_in.
- ld_valid and st_valid held high continuously with STARVE_LIMIT=4 -> 4 loads granted, then store granted, then starve_cnt=0.
- LW addr 0x1002 -> ld_ready 1, misalign_err pulse, mem_req stays 0; load f3 111 gives the same.
- rst asserted during WAIT_RSP -> all outputs 0 immediately; a later mem_rvalid is ignored (no rd_valid_in).

Source files
------------

// File: rtl/lsu_mem_sched.sv
// lsu_mem_sched: load/store arbiter and sequencer for the single data-memory port,
// handing each load's raw doubleword to the load formatter.
module lsu_mem_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [63:0] ld_addr,
  input  logic [2:0]  ld_f3,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [2:0]  st_f3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        rd_valid_in,
  output logic [63:0] rd_mem_data,
  output logic [7:0]  rd_be_mask,
  output logic [2:0]  rd_f3,
  output logic        rd_is_load_64,
  input  logic        rd_ready_out,
  output logic        misalign_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DELIVER} state_t;
  state_t state;
  logic [CNT_W-1:0] starve_cnt;
  logic idle, starve, acc, bad;
  logic [63:0] addr;
  logic [2:0] f3, o;
  logic [7:0] mask;
  assign idle = state == IDLE;
  assign starve = starve_cnt == CNT_W'(STARVE_LIMIT);
  // ready is gated by rst so every output reads 0 while reset is held
  assign ld_ready = rst && idle && ld_valid && !(st_valid && starve);
  assign st_ready = rst && idle && st_valid && (!ld_valid || starve);
  assign acc = ld_ready || st_ready;
  assign addr = st_ready ? st_addr : ld_addr;
  assign f3 = st_ready ? st_f3 : ld_f3;
  assign o = addr[2:0];
  assign mask = f3[1:0] == 2'd0 ? 8'h01 << o :
                f3[1:0] == 2'd1 ? 8'h03 << o :
                f3[1:0] == 2'd2 ? 8'h0F << o : 8'hFF;
  assign bad = (f3[1:0] == 2'd1 && o[0]) || (f3[1:0] == 2'd2 && |o[1:0]) ||
               (f3[1:0] == 2'd3 && |o) || (st_ready ? f3[2] : &f3);
  assign mem_req = state == REQ;
  assign rd_valid_in = state == DELIVER;
  assign busy = !idle;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rd_mem_data <= '0;
      rd_be_mask <= '0;
      rd_f3 <= '0;
      rd_is_load_64 <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= acc && bad;
      // a load can only win while the counter is below the limit, so this saturates
      if (st_ready) starve_cnt <= '0;
      else if (ld_ready && st_valid) starve_cnt <= starve_cnt + CNT_W'(1);
      case (state)
        IDLE: if (acc && !bad) begin
          state <= REQ;
          mem_we <= st_ready;
          mem_addr <= {addr[63:3], 3'b000};
          mem_wdata <= st_ready ? st_data << {o, 3'b000} : '0;
          mem_wstrb <= st_ready ? mask : '0;
          if (!st_ready) begin
            rd_be_mask <= mask;
            rd_f3 <= f3;
            rd_is_load_64 <= f3 == 3'b011;
          end
        end
        REQ: if (mem_gnt) state <= mem_we ? IDLE : WAIT_RSP;
        WAIT_RSP: if (mem_rvalid) begin
          rd_mem_data <= mem_rdata;
          state <= DELIVER;
        end
        DELIVER: if (rd_ready_out) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_sched.sv
// tb_lsu_mem_sched: directed stimulus with a transaction-level model checked every cycle.
module tb_lsu_mem_sched;
  logic clk = 0, rst = 0;
  logic ld_valid = 0, st_valid = 0, mem_gnt = 0, mem_rvalid = 0, rd_ready_out = 0;
  logic [63:0] ld_addr = 0, st_addr = 0, st_data = 0, mem_rdata = 0;
  logic [2:0] ld_f3 = 0, st_f3 = 0;
  logic ld_ready, st_ready, mem_req, mem_we, rd_valid_in, rd_is_load_64, misalign_err, busy;
  logic [63:0] mem_addr, mem_wdata, rd_mem_data;
  logic [7:0] mem_wstrb, rd_be_mask;
  logic [2:0] rd_f3;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  lsu_mem_sched dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_f3(ld_f3),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_f3(st_f3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_valid_in(rd_valid_in), .rd_mem_data(rd_mem_data), .rd_be_mask(rd_be_mask),
    .rd_f3(rd_f3), .rd_is_load_64(rd_is_load_64), .rd_ready_out(rd_ready_out),
    .misalign_err(misalign_err), .busy(busy)
  );

  typedef struct packed {logic bad; logic [63:0] a; logic [63:0] wd; logic [7:0] m;} txn_t;

  // byte lanes [o, o+size) are enabled; misaligned when o is not a multiple of size
  function automatic txn_t model(input logic is_st, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [2:0] f3);
    txn_t t;
    int o, sz;
    o = int'(addr[2:0]);
    sz = 1 << f3[1:0];
    t.a = addr & ~64'd7;
    for (int i = 0; i < 8; i++) t.m[i] = (i >= o) && (i < o + sz);
    t.wd = data << (8 * o);
    t.bad = (o % sz != 0) || (is_st ? f3 > 3'd3 : f3 == 3'd7);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {ld_ready, st_ready, mem_req, mem_we, rd_valid_in, rd_is_load_64, misalign_err, busy}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rd_data"}, rd_mem_data, 0);
    chk({tag, "_masks"}, {mem_wstrb, rd_be_mask, rd_f3}, 0);
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  txn_t exp_t;
  logic exp_we = 0, pending = 0, mis_exp = 0, got;
  logic [2:0] exp_f3 = 0;
  logic [63:0] exp_rdata = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pending = 0;
      mis_exp = 0;
    end else begin
      chk("misalign_err", misalign_err, mis_exp);
      chk("activity_without_txn", (mem_req || rd_valid_in) && !pending, 0);
      if (mem_req) begin
        chk("m_mem_addr", mem_addr, exp_t.a);
        chk("m_mem_we", mem_we, exp_we);
        chk("m_mem_wstrb", mem_wstrb, exp_we ? exp_t.m : 8'h00);
        if (exp_we) chk("m_mem_wdata", mem_wdata, exp_t.wd);
      end
      if (rd_valid_in) begin
        chk("m_rd_is_load", exp_we, 0);
        chk("m_rd_mem_data", rd_mem_data, exp_rdata);
        chk("m_rd_be_mask", rd_be_mask, exp_t.m);
        chk("m_rd_f3", rd_f3, exp_f3);
        chk("m_rd_is_load_64", rd_is_load_64, exp_f3 == 3'b011);
      end
      if ((mem_req && mem_gnt && exp_we) || (rd_valid_in && rd_ready_out)) pending = 0;
      mis_exp = 0;
      if ((ld_valid && ld_ready) || (st_valid && st_ready)) begin
        chk("one_outstanding", pending, 0);
        chk("single_winner", ld_ready && st_ready, 0);
        exp_we = st_valid && st_ready;
        exp_t = exp_we ? model(1'b1, st_addr, st_data, st_f3) : model(1'b0, ld_addr, 64'd0, ld_f3);
        exp_f3 = exp_we ? st_f3 : ld_f3;
        mis_exp = exp_t.bad;
        pending = !exp_t.bad;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    smp; chk_zero("reset");
    tick; rst = 1;
    smp; chk("post_reset_busy", busy, 0);
    // LB at byte offset 3, minimum latency
    tick; ld_valid = 1; ld_addr = 64'h1003; ld_f3 = 3'b000;
    mem_gnt = 1; mem_rvalid = 1; rd_ready_out = 1;
    mem_rdata = 64'h00000000FF000000; exp_rdata = mem_rdata;
    smp; chk("lb_ld_ready", ld_ready, 1); chk("lb_st_ready", st_ready, 0);
    tick; ld_valid = 0;
    smp; chk("lb_req", mem_req, 1); chk("lb_addr", mem_addr, 64'h1000); chk("lb_wstrb", mem_wstrb, 0);
    tick; smp; chk("lb_wait_rv", rd_valid_in, 0); chk("lb_wait_busy", busy, 1);
    tick; smp; chk("lb_rv", rd_valid_in, 1); chk("lb_mask", rd_be_mask, 8'h08);
    chk("lb_f3", rd_f3, 3'b000); chk("lb_is64", rd_is_load_64, 0);
    chk("lb_data", rd_mem_data, 64'h00000000FF000000);
    tick; smp; chk("lb_done", busy, 0); chk("lb_rv_drop", rd_valid_in, 0);
    // LD with grant delayed two cycles and reader stalled two cycles
    tick; ld_valid = 1; ld_addr = 64'h2000; ld_f3 = 3'b011; mem_gnt = 0; rd_ready_out = 0;
    mem_rdata = 64'h123456789ABCDEF0; exp_rdata = mem_rdata;
    smp; chk("ld_ld_ready", ld_ready, 1);
    tick; ld_valid = 0;
    for (int i = 0; i < 3; i++) begin
      mem_gnt = (i == 2);
      smp; chk("ld_req_hold", mem_req, 1); chk("ld_addr", mem_addr, 64'h2000);
      tick;
    end
    mem_gnt = 0;
    smp; chk("ld_req_drop", mem_req, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      rd_ready_out = (i == 2);
      smp; chk("ld_rv_hold", rd_valid_in, 1); chk("ld_data", rd_mem_data, 64'h123456789ABCDEF0);
      chk("ld_mask", rd_be_mask, 8'hFF); chk("ld_is64", rd_is_load_64, 1);
      tick;
    end
    rd_ready_out = 1;
    smp; chk("ld_rv_drop", rd_valid_in, 0); chk("ld_done", busy, 0);
    // SH at offset 6: posted write, no reader activity
    tick; st_valid = 1; st_addr = 64'h3006; st_data = 64'hBEEF; st_f3 = 3'b001; mem_gnt = 1;
    smp; chk("sh_st_ready", st_ready, 1); chk("sh_ld_ready", ld_ready, 0);
    tick; st_valid = 0;
    smp; chk("sh_req", mem_req, 1); chk("sh_we", mem_we, 1); chk("sh_wstrb", mem_wstrb, 8'hC0);
    chk("sh_wdata", mem_wdata, 64'hBEEF000000000000); chk("sh_addr", mem_addr, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      tick; smp; chk("sh_idle", {busy, mem_req, rd_valid_in}, 0);
    end
    // both requesters held: four loads, then the starved store, then a load again
    tick; ld_valid = 1; ld_addr = 64'h4000; ld_f3 = 3'b011;
    st_valid = 1; st_addr = 64'h5000; st_data = 64'h1111; st_f3 = 3'b011;
    mem_rdata = 64'hCAFEF00DDEADBEEF; exp_rdata = mem_rdata;
    for (int n = 0; n < 6; n++) begin
      got = 0;
      for (int w = 0; w < 12 && !got; w++) begin
        smp;
        got = ld_ready || st_ready;
      end
      chk("starve_grant_seen", got, 1);
      chk("starve_grant_is_store", st_ready, n == 4);
      tick;
    end
    ld_valid = 0; st_valid = 0;
    got = 0;
    for (int w = 0; w < 12 && !got; w++) begin
      smp;
      got = !busy;
    end
    chk("starve_drain", got, 1);
    // misaligned LW, then illegal load f3, back to back
    tick; ld_valid = 1; ld_addr = 64'h1002; ld_f3 = 3'b010;
    smp; chk("lw_mis_ready", ld_ready, 1);
    tick; ld_addr = 64'h1000; ld_f3 = 3'b111;
    smp; chk("lw_mis_pulse", misalign_err, 1); chk("lw_mis_noreq", {busy, mem_req}, 0);
    chk("ill_ready", ld_ready, 1);
    tick; ld_valid = 0;
    smp; chk("ill_pulse", misalign_err, 1); chk("ill_noreq", {busy, mem_req}, 0);
    tick; smp; chk("mis_pulse_end", misalign_err, 0); chk("mis_idle", busy, 0);
    // reset while mem_req is high
    tick; ld_valid = 1; ld_addr = 64'h6000; ld_f3 = 3'b011; mem_gnt = 0; mem_rvalid = 0;
    smp; tick; ld_valid = 0;
    smp; chk("rq_req", mem_req, 1);
    #1 rst = 0; ld_valid = 1;
    #1 chk_zero("rst_in_req");
    smp; tick; rst = 1; ld_valid = 0;
    smp; chk("rq_after", busy, 0);
    // reset while waiting for read data; late rvalid must be ignored
    tick; ld_valid = 1; mem_gnt = 1;
    smp; tick; ld_valid = 0;
    smp; tick;
    smp; chk("rw_wait_busy", busy, 1); chk("rw_wait_req", mem_req, 0);
    #1 rst = 0; ld_valid = 1;
    #1 chk_zero("rst_in_wait");
    smp; tick; rst = 1; ld_valid = 0; mem_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      smp; chk("rw_no_deliver", {busy, rd_valid_in}, 0);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
